// File: rtl/serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_if
//   Request/result bundle for the bit-serial add/subtract controller.
//   master : drives start, sub, c_in, a, b; observes busy, done, sum,
//            c_out, overflow.
//   slave  : the controller side (mirror of master).
// ---------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             c_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output start, sub, c_in, a, b,
        input  busy, done, sum, c_out, overflow
    );

    modport slave (
        input  start, sub, c_in, a, b,
        output busy, done, sum, c_out, overflow
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial add/subtract controller. One full_adder cell is reused for
//   every bit position, LSB first, with a registered carry between bits.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - serial_add_ctrl_if.slave: start/sub/c_in/a/b request,
//              busy/done/sum/c_out/overflow status and result
//   Latency is WIDTH clocks from the accepting edge to the done pulse.
// ---------------------------------------------------------------------------

// One-bit full adder built from gates only; the only arithmetic element.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);
    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg,    state_next;
    logic [WIDTH-1:0]   a_sh_reg,     a_sh_next;
    logic [WIDTH-1:0]   b_sh_reg,     b_sh_next;
    logic [WIDTH-1:0]   s_sh_reg,     s_sh_next;
    logic               cy_reg,       cy_next;
    logic [CNT_W-1:0]   cnt_reg,      cnt_next;
    logic [WIDTH-1:0]   sum_reg,      sum_next;
    logic               c_out_reg,    c_out_next;
    logic               overflow_reg, overflow_next;

    logic cell_s;
    logic cell_c_out;
    logic ovf_bit;

    full_adder u_cell (
        .a     (a_sh_reg[0]),
        .b     (b_sh_reg[0]),
        .c_in  (cy_reg),
        .s     (cell_s),
        .c_out (cell_c_out)
    );

    // Only meaningful on the MSB cycle: carry into MSB xor carry out of MSB.
    assign ovf_bit = cy_reg ^ cell_c_out;

    always_comb begin
        state_next    = state_reg;
        a_sh_next     = a_sh_reg;
        b_sh_next     = b_sh_reg;
        s_sh_next     = s_sh_reg;
        cy_next       = cy_reg;
        cnt_next      = cnt_reg;
        sum_next      = sum_reg;
        c_out_next    = c_out_reg;
        overflow_next = overflow_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = RUN;
                    a_sh_next  = bus.a;
                    // Subtraction is A + ~B + 1; c_in then acts as a borrow,
                    // so the initial carry is inverted when sub is set.
                    b_sh_next  = bus.sub ? ~bus.b : bus.b;
                    cy_next    = bus.c_in ^ bus.sub;
                    cnt_next   = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                s_sh_next = {cell_s, s_sh_reg[WIDTH-1:1]};
                a_sh_next = a_sh_reg >> 1;
                b_sh_next = b_sh_reg >> 1;
                cy_next   = cell_c_out;
                if (cnt_reg == CNT_LAST) begin
                    // Counter parks at zero rather than reaching WIDTH.
                    state_next    = DONE;
                    cnt_next      = '0;
                    sum_next      = {cell_s, s_sh_reg[WIDTH-1:1]};
                    c_out_next    = cell_c_out;
                    overflow_next = ovf_bit;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            a_sh_reg     <= '0;
            b_sh_reg     <= '0;
            s_sh_reg     <= '0;
            cy_reg       <= 1'b0;
            cnt_reg      <= '0;
            sum_reg      <= '0;
            c_out_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            a_sh_reg     <= a_sh_next;
            b_sh_reg     <= b_sh_next;
            s_sh_reg     <= s_sh_next;
            cy_reg       <= cy_next;
            cnt_reg      <= cnt_next;
            sum_reg      <= sum_next;
            c_out_reg    <= c_out_next;
            overflow_reg <= overflow_next;
        end
    end

    assign bus.busy     = (state_reg == RUN);
    assign bus.done     = (state_reg == DONE);
    assign bus.sum      = sum_reg;
    assign bus.c_out    = c_out_reg;
    assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
//   Drives an 8-bit and a 2-bit serial_add_ctrl through directed cases,
//   back-to-back and mid-run reset scenarios, then random regressions.
//   Expected results come from plain signed/unsigned integer arithmetic.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;
    logic clk;
    logic rst_n;

    int checks;
    int errors;

    // Last completed result per DUT, packed {overflow, c_out, sum[7:0]}.
    logic [9:0] last_res [2];

    serial_add_ctrl_if #(.WIDTH(8)) if8 ();
    serial_add_ctrl_if #(.WIDTH(2)) if2 ();

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, c_out, sum} from integer arithmetic on w bits.
    function automatic logic [9:0] model(input int w, input logic [7:0] a, input logic [7:0] b,
                                         input logic s, input logic ci);
        longint mask, ua, ub, c, full, half, sa, sb, sr;
        logic   cout, ovf;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        c    = longint'(ci);
        if (!s) begin
            full = ua + ub + c;
            cout = (full > mask);
        end else begin
            full = ua - ub - c;
            cout = (ua >= ub + c);   // 1 = no borrow
        end
        half = longint'(1) << (w - 1);
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        sr   = s ? (sa - sb - c) : (sa + sb + c);
        ovf  = (sr < -half) || (sr > half - 1);
        return {ovf, cout, 8'(full & mask)};
    endfunction

    task automatic drive(input int w, input logic st, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic ci);
        if (w == 8) begin
            if8.start = st; if8.a = a; if8.b = b; if8.sub = s; if8.c_in = ci;
        end else begin
            if2.start = st; if2.a = a[1:0]; if2.b = b[1:0]; if2.sub = s; if2.c_in = ci;
        end
    endtask

    task automatic set_start(input int w, input logic st);
        if (w == 8) if8.start = st;
        else        if2.start = st;
    endtask

    function automatic logic get_busy(input int w);
        return (w == 8) ? if8.busy : if2.busy;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 8) ? if8.done : if2.done;
    endfunction

    function automatic logic [9:0] get_res(input int w);
        if (w == 8) return {if8.overflow, if8.c_out, if8.sum};
        return {if2.overflow, if2.c_out, 6'b0, if2.sum};
    endfunction

    // One complete operation: accept, wait (bounded) for done, check result,
    // busy length and that done lasts a single cycle.
    task automatic op(input int w, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic ci, input string tag, input bit directed);
        logic [9:0] exp;
        int         busy_n;
        bit         seen;
        int         idx;
        idx    = (w == 8) ? 0 : 1;
        exp    = model(w, a, b, s, ci);
        drive(w, 1'b1, a, b, s, ci);
        step();
        set_start(w, 1'b0);
        busy_n = 0;
        seen   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (get_done(w)) begin
                seen = 1'b1;
                break;
            end
            if (get_busy(w)) busy_n++;
            if (directed) chk({tag, " hold"}, 32'(get_res(w)), 32'(last_res[idx]));
            step();
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " result"}, 32'(get_res(w)), 32'(exp));
        if (directed) begin
            chk({tag, " busy_cycles"}, busy_n, w);
            chk({tag, " busy_at_done"}, 32'(get_busy(w)), 32'd0);
        end
        step();
        chk({tag, " done_width"}, 32'(get_done(w)), 32'd0);
        last_res[idx] = exp;
        $display("op w=%0d %s a=%h b=%h sub=%0d c_in=%0d -> res=%h exp=%h",
                 w, tag, a, b, s, ci, get_res(w), exp);
    endtask

    initial begin
        logic [9:0] exp1, exp2;
        int         n;
        bit         seen;

        checks      = 0;
        errors      = 0;
        last_res[0] = '0;
        last_res[1] = '0;
        rst_n       = 1'b0;
        drive(8, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(2, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        step();
        step();
        rst_n = 1'b1;

        // Reset state
        chk("rst busy8", 32'(if8.busy), 32'd0);
        chk("rst done8", 32'(if8.done), 32'd0);
        chk("rst res8",  32'(get_res(8)), 32'd0);
        chk("rst busy2", 32'(if2.busy), 32'd0);
        chk("rst res2",  32'(get_res(2)), 32'd0);

        // Directed WIDTH=8 cases
        op(8, 8'h3C, 8'h5A, 1'b0, 1'b0, "add_3c_5a", 1'b1);
        chk("add_3c_5a exact", 32'(get_res(8)), 32'({1'b1, 1'b0, 8'h96}));
        op(8, 8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01", 1'b1);
        chk("add_ff_01 exact", 32'(get_res(8)), 32'({1'b0, 1'b1, 8'h00}));
        op(8, 8'h7F, 8'h00, 1'b0, 1'b1, "add_7f_cin", 1'b1);
        chk("add_7f_cin exact", 32'(get_res(8)), 32'({1'b1, 1'b0, 8'h80}));
        op(8, 8'h05, 8'h07, 1'b1, 1'b0, "sub_05_07", 1'b1);
        chk("sub_05_07 exact", 32'(get_res(8)), 32'({1'b0, 1'b0, 8'hFE}));
        op(8, 8'h80, 8'h01, 1'b1, 1'b0, "sub_80_01", 1'b1);
        chk("sub_80_01 exact", 32'(get_res(8)), 32'({1'b1, 1'b1, 8'h7F}));
        op(8, 8'h10, 8'h01, 1'b1, 1'b1, "sub_10_01_b", 1'b1);
        chk("sub_10_01_b sum", 32'(if8.sum), 32'h0E);

        // Back-to-back: start held during RUN with junk operands, then a
        // second request presented in the DONE cycle.
        exp1 = model(8, 8'h21, 8'h42, 1'b0, 1'b0);
        exp2 = model(8, 8'h50, 8'h13, 1'b1, 1'b0);
        drive(8, 1'b1, 8'h21, 8'h42, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 7; i++) begin
            drive(8, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        chk("b2b busy_e7", 32'(if8.busy), 32'd1);
        drive(8, 1'b1, 8'h50, 8'h13, 1'b1, 1'b0);
        step();
        chk("b2b done1", 32'(if8.done), 32'd1);
        chk("b2b res1", 32'(get_res(8)), 32'(exp1));
        step();
        chk("b2b done1_width", 32'(if8.done), 32'd0);
        chk("b2b busy_again", 32'(if8.busy), 32'd1);
        set_start(8, 1'b0);
        n    = 0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (if8.done) begin
                seen = 1'b1;
                break;
            end
            step();
            n++;
        end
        chk("b2b done2_seen", 32'(seen), 32'd1);
        chk("b2b done2_spacing", n, 8);
        chk("b2b res2", 32'(get_res(8)), 32'(exp2));
        step();
        chk("b2b done2_width", 32'(if8.done), 32'd0);
        last_res[0] = exp2;
        $display("b2b res1=%h res2=%h", exp1, exp2);

        // Reset in the middle of RUN at cnt=4
        drive(8, 1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
        step();
        set_start(8, 1'b0);
        for (int i = 0; i < 4; i++) step();
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst busy", 32'(if8.busy), 32'd0);
        chk("mid_rst done", 32'(if8.done), 32'd0);
        chk("mid_rst res",  32'(get_res(8)), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        last_res[0] = '0;
        last_res[1] = '0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (if8.done || if8.busy) seen = 1'b1;
            step();
        end
        chk("mid_rst no_activity", 32'(seen), 32'd0);
        $display("mid-run reset done");
        op(8, 8'hA5, 8'h3C, 1'b1, 1'b0, "post_rst", 1'b1);

        // Directed WIDTH=2 boundary cases
        op(2, 8'h01, 8'h01, 1'b0, 1'b0, "w2_add_1_1", 1'b1);
        op(2, 8'h02, 8'h01, 1'b1, 1'b0, "w2_sub_2_1", 1'b1);
        op(2, 8'h03, 8'h03, 1'b0, 1'b1, "w2_add_3_3c", 1'b1);

        // Random regressions
        for (int i = 0; i < 1000; i++)
            op(8, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "rnd8", 1'b0);
        for (int i = 0; i < 1000; i++)
            op(2, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), "rnd2", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
